// File: rtl/branch_pc_ctrl.sv
// Program-counter and branch-resolution controller for the 16-bit pipeline.
// Resolves conditional B/BR branches sitting in decode against the flag
// register, redirects the fetch PC, squashes the wrong-path fetch and parks
// the core on HLT. A conditional branch whose flags are being written by the
// instruction in execute waits one cycle in WAIT_FLAGS before resolving.
//
// Handshake: there is no valid/ready pair here. ext_stall is an absolute
// freeze owned by the hazard unit; fe_stall is this block's own request to
// hold IF/ID and is driven combinationally in the cycle it is needed.
module branch_pc_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_stall,
    input  logic        id_valid,
    input  logic [15:0] id_pc,
    input  logic        id_is_b,
    input  logic        id_is_br,
    input  logic        id_is_hlt,
    input  logic [2:0]  id_cond,
    input  logic [8:0]  id_imm9,
    input  logic [15:0] id_br_tgt,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_v,
    input  logic        ex_flag_wr,
    output logic [15:0] pc,
    output logic        fe_stall,
    output logic        flush,
    output logic        br_taken,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        halted_q, halted_d;
    logic        fe_stall_c;
    logic        br_taken_c;

    logic        cond_met;
    logic        is_hlt;
    logic        is_branch;
    logic        is_uncond;
    logic [15:0] b_tgt;
    logic [15:0] tgt;
    logic [15:0] pc_seq;

    // Decode classification; HLT outranks B, B outranks BR.
    assign is_hlt    = id_valid && id_is_hlt;
    assign is_branch = id_valid && !id_is_hlt && (id_is_b || id_is_br);
    assign is_uncond = (id_cond == 3'b111);
    assign b_tgt     = id_pc + 16'd2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};
    assign tgt       = id_is_b ? b_tgt : id_br_tgt;
    assign pc_seq    = pc_q + PC_STEP;

    // Condition-code evaluation against the current flag register.
    always_comb begin
        cond_met = 1'b0;
        case (id_cond)
            3'b000:  cond_met = !flag_z;
            3'b001:  cond_met = flag_z;
            3'b010:  cond_met = !flag_z && !flag_n;
            3'b011:  cond_met = flag_n;
            3'b100:  cond_met = flag_z || (!flag_z && !flag_n);
            3'b101:  cond_met = flag_n || flag_z;
            3'b110:  cond_met = flag_v;
            default: cond_met = 1'b1;
        endcase
    end

    // Next-state, next-PC and combinational stall/taken outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        halted_d   = halted_q;
        fe_stall_c = 1'b0;
        br_taken_c = 1'b0;
        if (!ext_stall) begin
            case (state_q)
                ST_RUN, ST_WAIT: begin
                    // WAIT_FLAGS lasts exactly one cycle and keeps decode held.
                    state_d    = ST_RUN;
                    fe_stall_c = (state_q == ST_WAIT);
                    if (is_hlt) begin
                        state_d  = ST_HALT;
                        flush_d  = 1'b1;
                        halted_d = 1'b1;
                    end else if (is_branch) begin
                        if (state_q == ST_RUN && !is_uncond && ex_flag_wr) begin
                            state_d    = ST_WAIT;
                            fe_stall_c = 1'b1;
                        end else if (cond_met) begin
                            br_taken_c = 1'b1;
                            pc_d       = tgt;
                            flush_d    = 1'b1;
                        end else begin
                            pc_d = pc_seq;
                        end
                    end else begin
                        pc_d = pc_seq;
                    end
                end
                ST_HALT: begin
                    halted_d = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, PC and registered outputs; reset wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign halted    = halted_q;
    assign fe_stall  = fe_stall_c;
    assign br_taken  = br_taken_c;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Self-checking bench for branch_pc_ctrl: directed scenarios followed by
// randomized decode traffic, all checked against a cycle-level reference
// model built from the branch/condition/halt rules.
module tb_branch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_stall;
    logic        id_valid;
    logic [15:0] id_pc;
    logic        id_is_b;
    logic        id_is_br;
    logic        id_is_hlt;
    logic [2:0]  id_cond;
    logic [8:0]  id_imm9;
    logic [15:0] id_br_tgt;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic        ex_flag_wr;
    logic [15:0] pc;
    logic        fe_stall;
    logic        flush;
    logic        br_taken;
    logic        halted;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_pc;
    bit m_wait;
    bit m_halted;
    bit m_flush;
    // Model outputs for the current cycle and values for the next one
    bit e_fe_stall, e_br_taken;
    int n_pc;
    bit n_wait, n_halted, n_flush;

    branch_pc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_pc(id_pc), .id_is_b(id_is_b), .id_is_br(id_is_br), .id_is_hlt(id_is_hlt),
        .id_cond(id_cond), .id_imm9(id_imm9), .id_br_tgt(id_br_tgt),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .ex_flag_wr(ex_flag_wr),
        .pc(pc), .fe_stall(fe_stall), .flush(flush), .br_taken(br_taken),
        .halted(halted), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_true(input logic [2:0] c, input bit z, input bit n, input bit v);
        case (c)
            3'd0: return z == 0;
            3'd1: return z == 1;
            3'd2: return z == 0 && n == 0;
            3'd3: return n == 1;
            3'd4: return z == 1 || (z == 0 && n == 0);
            3'd5: return n == 1 || z == 1;
            3'd6: return v == 1;
            default: return 1;
        endcase
    endfunction

    // Compute what this cycle should look like from the rules, given current inputs.
    task automatic model_eval();
        int off;
        e_fe_stall = 0;
        e_br_taken = 0;
        n_pc       = m_pc;
        n_wait     = m_wait;
        n_halted   = m_halted;
        n_flush    = 0;
        if (!m_halted && !ext_stall) begin
            n_wait     = 0;
            e_fe_stall = m_wait;
            if (id_valid && id_is_hlt) begin
                n_halted = 1;
                n_flush  = 1;
            end else if (id_valid && (id_is_b || id_is_br)) begin
                if (!m_wait && id_cond != 3'd7 && ex_flag_wr) begin
                    n_wait     = 1;
                    e_fe_stall = 1;
                end else if (cond_true(id_cond, flag_z, flag_n, flag_v)) begin
                    e_br_taken = 1;
                    n_flush    = 1;
                    off = id_imm9[8] ? int'(id_imm9) - 512 : int'(id_imm9);
                    n_pc = id_is_b ? ((int'(id_pc) + 2 + 2 * off) & 32'hFFFF) : int'(id_br_tgt);
                end else begin
                    n_pc = (m_pc + 2) & 32'hFFFF;
                end
            end else begin
                n_pc = (m_pc + 2) & 32'hFFFF;
            end
        end
    endtask

    // One clock: inputs already driven; check comb outputs mid-cycle, registered after edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        check("fe_stall", {15'd0, fe_stall}, {15'd0, e_fe_stall});
        check("br_taken", {15'd0, br_taken}, {15'd0, e_br_taken});
        @(posedge clk);
        m_pc = n_pc; m_wait = n_wait; m_halted = n_halted; m_flush = n_flush;
        #1;
        check("pc", pc, m_pc[15:0]);
        check("flush", {15'd0, flush}, {15'd0, m_flush});
        check("halted", {15'd0, halted}, {15'd0, m_halted});
    endtask

    task automatic set_idle();
        ext_stall = 0; id_valid = 0; id_pc = 0; id_is_b = 0; id_is_br = 0; id_is_hlt = 0;
        id_cond = 0; id_imm9 = 0; id_br_tgt = 0; flag_z = 0; flag_n = 0; flag_v = 0;
        ex_flag_wr = 0;
    endtask

    task automatic drive(input bit b, input bit br, input bit hlt, input logic [2:0] c,
                         input logic [8:0] imm, input logic [15:0] ipc, input logic [15:0] t,
                         input bit z, input bit n, input bit v, input bit wr);
        id_valid = 1; id_is_b = b; id_is_br = br; id_is_hlt = hlt; id_cond = c;
        id_imm9 = imm; id_pc = ipc; id_br_tgt = t; flag_z = z; flag_n = n; flag_v = v;
        ex_flag_wr = wr;
    endtask

    // Asynchronous reset applied mid-cycle; returns just after a rising edge.
    task automatic do_reset();
        set_idle();
        rst_n = 0;
        #2;
        m_pc = 0; m_wait = 0; m_halted = 0; m_flush = 0;
        check("rst_pc", pc, 16'h0000);
        check("rst_flush", {15'd0, flush}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_fe_stall", {15'd0, fe_stall}, 16'd0);
        check("rst_br_taken", {15'd0, br_taken}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    logic [15:0] p0;

    initial begin
        set_idle();
        rst_n = 1;
        m_pc = 0; m_wait = 0; m_halted = 0; m_flush = 0;
        #3;
        do_reset();

        // Sequential stepping
        for (int i = 0; i < 3; i++) step();
        check("seq_pc", pc, 16'h0006);

        // B EQ taken, backwards offset
        drive(1, 0, 0, 3'b001, 9'h1FE, 16'h0010, 16'h0000, 1, 0, 0, 0);
        step();
        check("b_eq_pc", pc, 16'h000E);
        check("b_eq_flush", {15'd0, flush}, 16'd1);
        set_idle();
        step();
        check("b_eq_flush_drop", {15'd0, flush}, 16'd0);

        // B NE waits for the flag write, then resolves not taken
        drive(1, 0, 0, 3'b000, 9'h004, 16'h0020, 16'h0000, 0, 0, 0, 1);
        p0 = pc;
        step();
        check("wait_pc_hold", pc, p0);
        flag_z = 1; ex_flag_wr = 0;
        step();
        check("wait_not_taken", pc, p0 + 16'd2);
        set_idle();
        step();

        // Unconditional BR never waits; sequential wrap
        drive(0, 1, 0, 3'b111, 9'h000, 16'h0040, 16'hFFFE, 0, 0, 0, 1);
        step();
        check("br_uncond_pc", pc, 16'hFFFE);
        set_idle();
        step();
        check("wrap_pc", pc, 16'h0000);

        // ext_stall freezes a taken branch until it drops
        drive(0, 1, 0, 3'b111, 9'h000, 16'h0000, 16'h1234, 0, 0, 0, 0);
        ext_stall = 1;
        step();
        step();
        check("xstall_pc", pc, 16'h0000);
        ext_stall = 0;
        step();
        check("xstall_release_pc", pc, 16'h1234);
        set_idle();
        step();

        // HLT at 0020 parks the core
        do_reset();
        for (int i = 0; i < 16; i++) step();
        drive(0, 0, 1, 3'b111, 9'h000, 16'h0020, 16'h0000, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 12; i++) begin
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 3'b111,
                  9'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0, 0);
            step();
        end
        check("hlt_pc", pc, 16'h0020);
        check("hlt_halted", {15'd0, halted}, 16'd1);

        // Reset asserted while waiting for flags
        do_reset();
        step();
        drive(1, 0, 0, 3'b011, 9'h010, 16'h0002, 16'h0000, 0, 1, 0, 1);
        step();
        do_reset();
        check("rst_wait_state", {14'd0, dbg_state}, 16'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ext_stall  = ($urandom_range(0, 99) < 15);
            id_valid   = ($urandom_range(0, 99) < 85);
            id_is_hlt  = ($urandom_range(0, 99) < 3);
            id_is_b    = ($urandom_range(0, 1) == 1);
            id_is_br   = ($urandom_range(0, 1) == 1);
            id_cond    = 3'($urandom_range(0, 7));
            id_imm9    = 9'($urandom);
            id_pc      = 16'($urandom);
            id_br_tgt  = 16'($urandom);
            flag_z     = 1'($urandom);
            flag_n     = 1'($urandom);
            flag_v     = 1'($urandom);
            ex_flag_wr = ($urandom_range(0, 99) < 40);
            step();
            if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 99) == 0)
                do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
